// File: rtl/buzzer_sequencer.sv
// Note FIFO and replay sequencer for the buzzer peripheral. Notes are queued over the
// slow CPU bus and played back by driving the buzzer's register port as its only master.
module buzzer_sequencer #(
  parameter int          DEPTH      = 8,
  parameter int          AW         = 3,
  parameter logic [31:0] GAP_CYCLES = 32'd500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_cpu,
  input  logic [31:2] Addr,
  input  logic [31:0] Din,
  input  logic        WE,
  output logic [31:0] Dout,
  output logic        irq,
  output logic [3:2]  bz_addr,
  output logic [31:0] bz_din,
  output logic        bz_we,
  output logic        bz_clk,
  input  logic [31:0] bz_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_FREQ, S_WR_DUR, S_WR_GO, S_WAIT, S_REST, S_GAP, S_STOP
  } state_t;

  localparam logic [1:0]  REG_CTRL   = 2'd0;
  localparam logic [1:0]  REG_FREQ   = 2'd1;
  localparam logic [1:0]  REG_DUR    = 2'd2;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // CPU-side registers
  logic          clk_cpu_l;
  logic          enable;
  logic          irq_en;
  logic          overflow;
  logic [31:0]   freq_stage;

  // FIFO
  logic [31:0]   fifo_freq [DEPTH];
  logic [31:0]   fifo_dur  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;

  // Sequencer
  state_t        state;
  logic [1:0]    step;
  logic [31:0]   note_dur;
  logic [31:0]   timer;

  logic cpu_wr, wr_ctrl, wr_stage, wr_push, flush;
  logic pop, push_ok, abort, busy;
  logic [31:0] head_freq, head_dur;

  // Only the upper address bits and the buzzer's non-run bits go unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, Addr[31:4], bz_dout[31:1]};

  // The CPU clock is slow, so its rising edge is caught in the clk domain.
  assign cpu_wr   = WE & clk_cpu & ~clk_cpu_l;
  assign wr_ctrl  = cpu_wr & (Addr[3:2] == 2'd0);
  assign wr_stage = cpu_wr & (Addr[3:2] == 2'd2);
  assign wr_push  = cpu_wr & (Addr[3:2] == 2'd3);
  assign flush    = wr_ctrl & Din[1];

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign busy      = (state != S_IDLE);
  assign pop       = (state == S_IDLE) & enable & ~empty & ~flush;
  assign push_ok   = wr_push & (~full | pop);
  assign abort     = ~enable | flush;
  assign head_freq = fifo_freq[rd_ptr];
  assign head_dur  = fifo_dur[rd_ptr];
  assign irq       = irq_en & empty & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cpu_l  <= 1'b0;
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      overflow   <= 1'b0;
      freq_stage <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      clk_cpu_l <= clk_cpu;
      if (wr_ctrl) begin
        enable   <= Din[0];
        irq_en   <= Din[2];
        overflow <= 1'b0;
      end
      if (wr_stage) freq_stage <= Din;
      if (wr_push && !push_ok) overflow <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      count <= count + 1'b1;
        else if (pop && !push_ok) count <= count - 1'b1;
      end
    end
  end

  // NOTE: the note storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_freq[wr_ptr] <= freq_stage;
      fifo_dur[wr_ptr]  <= Din;
    end
  end

  // Bus outputs are registered; each write step is an A cycle (bz_clk high) then a B cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step     <= 2'd0;
      note_dur <= '0;
      timer    <= '0;
      bz_addr  <= REG_CTRL;
      bz_din   <= '0;
      bz_we    <= 1'b0;
      bz_clk   <= 1'b0;
    end else if (abort && state != S_IDLE && state != S_STOP) begin
      // Start STOP with one idle bus cycle so bz_clk is low before the CTRL=0 strobe.
      state   <= S_STOP;
      step    <= 2'd0;
      bz_addr <= REG_CTRL;
      bz_din  <= '0;
      bz_we   <= 1'b0;
      bz_clk  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            note_dur <= head_dur;
            if (head_freq != 32'd0) begin
              state   <= S_WR_FREQ;
              step    <= 2'd0;
              bz_addr <= REG_FREQ;
              bz_din  <= head_freq;
              bz_we   <= 1'b1;
              bz_clk  <= 1'b1;
            end else begin
              state <= S_REST;
              timer <= head_dur;
            end
          end
        end
        S_WR_FREQ, S_WR_DUR, S_WR_GO: begin
          if (step == 2'd0) begin
            step   <= 2'd1;
            bz_clk <= 1'b0;
          end else begin
            step <= 2'd0;
            if (state == S_WR_FREQ) begin
              state   <= S_WR_DUR;
              bz_addr <= REG_DUR;
              bz_din  <= note_dur;
              bz_clk  <= 1'b1;
            end else if (state == S_WR_DUR) begin
              state   <= S_WR_GO;
              bz_addr <= REG_CTRL;
              bz_din  <= 32'd1;
              bz_clk  <= 1'b1;
            end else begin
              state   <= S_WAIT;
              bz_addr <= REG_CTRL;
              bz_din  <= '0;
              bz_we   <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (!bz_dout[0]) begin
            if (GAP_CYCLES == 32'd0) state <= S_IDLE;
            else begin
              state <= S_GAP;
              timer <= GAP_CYCLES;
            end
          end
        end
        S_REST: begin
          if (timer <= 32'd1) begin
            if (GAP_CYCLES == 32'd0) state <= S_IDLE;
            else begin
              state <= S_GAP;
              timer <= GAP_CYCLES;
            end
          end else begin
            timer <= timer - 32'd1;
          end
        end
        S_GAP: begin
          if (timer <= 32'd1) state <= S_IDLE;
          else                timer <= timer - 32'd1;
        end
        S_STOP: begin
          case (step)
            2'd0: begin
              step   <= 2'd1;
              bz_we  <= 1'b1;
              bz_clk <= 1'b1;
            end
            2'd1: begin
              step   <= 2'd2;
              bz_clk <= 1'b0;
            end
            default: begin
              state <= S_IDLE;
              step  <= 2'd0;
              bz_we <= 1'b0;
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves Dout unassigned (no latch).
    Dout = '0;
    case (Addr[3:2])
      2'd0: Dout = {29'd0, irq_en, 1'b0, enable};
      2'd1: begin
        Dout[AW:0] = count;
        Dout[16]   = empty;
        Dout[17]   = full;
        Dout[18]   = busy;
        Dout[19]   = overflow;
      end
      2'd2:    Dout = freq_stage;
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer with a small buzzer register model on the bus.
`timescale 1ns/1ps
module tb_buzzer_sequencer;

  localparam int          DEPTH = 8;
  localparam int          AW    = 3;
  localparam logic [31:0] GAP   = 32'd20;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        clk_cpu = 1'b0;
  logic [31:2] addr    = 30'd1;
  logic [31:0] din     = '0;
  logic        we      = 1'b0;
  logic [31:0] dout;
  logic        irq;
  logic [3:2]  bz_addr;
  logic [31:0] bz_din;
  logic        bz_we;
  logic        bz_clk;
  logic [31:0] bz_dout;

  int n_checks = 0;
  int n_errors = 0;

  buzzer_sequencer #(.DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .clk_cpu(clk_cpu), .Addr(addr), .Din(din), .WE(we),
    .Dout(dout), .irq(irq), .bz_addr(bz_addr), .bz_din(bz_din), .bz_we(bz_we),
    .bz_clk(bz_clk), .bz_dout(bz_dout)
  );

  always #10 clk = ~clk;

  // Buzzer model: latches writes on bz_clk rising, CTRL[0] stays set for dur+1 clk cycles.
  typedef struct packed { logic [1:0] a; logic [31:0] d; } wr_t;
  wr_t wr_log[$];
  logic [31:0] m_ctrl = '0, m_freq = '0, m_dur = '0, m_remain = '0;
  logic        bz_clk_q = 1'b0;

  always @(posedge clk) begin
    bz_clk_q <= bz_clk;
    if (bz_clk && !bz_clk_q && bz_we) begin
      wr_log.push_back({bz_addr, bz_din});
      case (bz_addr)
        2'd0: begin m_ctrl <= bz_din; m_remain <= m_dur; end
        2'd1: m_freq <= bz_din;
        2'd2: m_dur  <= bz_din;
        default: ;
      endcase
    end else if (m_ctrl[0]) begin
      if (m_remain == 0) m_ctrl[0] <= 1'b0;
      else               m_remain  <= m_remain - 1;
    end
  end

  assign bz_dout = (bz_addr == 2'd0) ? m_ctrl :
                   (bz_addr == 2'd1) ? m_freq :
                   (bz_addr == 2'd2) ? m_dur  : '0;

  // Bus activity counters, sampled mid-cycle.
  int   busy_cnt = 0, we_cnt = 0, hi_cnt = 0, dbl_cnt = 0, gap_cnt = 0;
  logic hi_prev = 1'b0;

  always @(negedge clk) begin
    if (bz_we) we_cnt++;
    if (bz_clk) hi_cnt++;
    if (bz_clk && hi_prev) dbl_cnt++;
    hi_prev = bz_clk;
    if (addr == 30'd1 && dout[18]) begin
      busy_cnt++;
      if (!bz_we && !m_ctrl[0]) gap_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = {28'd0, a}; din = d; we = 1'b1; clk_cpu = 1'b1;
    @(negedge clk);
    clk_cpu = 1'b0; we = 1'b0; din = '0; addr = 30'd1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = {28'd0, a};
    #1 d = dout;
    addr = 30'd1;
  endtask

  task automatic wait_idle(input string tag, input bit need_empty, input int max_cyc);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((dout[18] || (need_empty && !dout[16])) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, {30'd0, dout[18], need_empty && !dout[16]}, 32'd0);
  endtask

  task automatic wait_playing(input string tag);
    int n = 0;
    while (!m_ctrl[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, m_ctrl[0]}, 32'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_wr(input string tag, input int k, input logic [1:0] a, input logic [31:0] d);
    if (k < wr_log.size()) begin
      check({tag, "_addr"}, {30'd0, wr_log[k].a}, {30'd0, a});
      check({tag, "_data"}, wr_log[k].d, d);
    end else begin
      check({tag, "_missing"}, wr_log.size(), k + 1);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bus_ctl", {29'd0, bz_clk, bz_we, bz_addr == 2'd0}, 32'd1);
    check("rst_bus_din", bz_din, 32'd0);
    rst_n = 1'b1;
    cpu_read(2'd0, rd); check("rst_ctrl", rd, 32'd0);
    cpu_read(2'd1, rd); check("rst_status", rd, 32'h0001_0000);
    cpu_read(2'd2, rd); check("rst_stage", rd, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Single note 1000/2000
    cpu_write(2'd2, 32'd1000);
    cpu_read(2'd2, rd); check("stage_readback", rd, 32'd1000);
    cpu_write(2'd3, 32'd2000);
    cpu_read(2'd1, rd); check("status_one", rd, 32'h0000_0001);
    cpu_read(2'd3, rd); check("push_reads_0", rd, 32'd0);
    wr_log.delete(); busy_cnt = 0; hi_cnt = 0; gap_cnt = 0;
    cpu_write(2'd0, 32'd5);
    // Enable commits on the edge before this negedge; the pop edge follows, raising bz_clk.
    @(negedge clk);
    check("first_strobe", {30'd0, bz_clk, bz_addr == 2'd1}, 32'd3);
    repeat (5) @(negedge clk);
    check("go_cycle_b", {29'd0, bz_we, bz_clk, bz_addr == 2'd0}, 32'd5);
    @(negedge clk);
    check("wait_bus_idle", {30'd0, bz_we, bz_clk}, 32'd0);
    wait_idle("note_idle", 1'b1, 3000);
    check("note_writes", wr_log.size(), 32'd3);
    check_wr("note_w0", 0, 2'd1, 32'd1000);
    check_wr("note_w1", 1, 2'd2, 32'd2000);
    check_wr("note_w2", 2, 2'd0, 32'd1);
    check("note_strobes", hi_cnt, 32'd3);
    // 6 write cycles + WAIT of dur+1 cycles + GAP
    check("note_busy", busy_cnt, 32'd6 + 32'd2001 + GAP);
    // one cycle for WAIT to see CTRL[0] clear, then GAP cycles
    check("note_gap", gap_cnt, GAP + 32'd1);
    check("note_irq", {31'd0, irq}, 32'd1);

    // Rest 0/300: no bus writes, busy for 300 + GAP cycles
    busy_cnt = 0; we_cnt = 0;
    cpu_write(2'd2, 32'd0);
    cpu_write(2'd3, 32'd300);
    wait_idle("rest_idle", 1'b1, 1000);
    check("rest_no_we", we_cnt, 32'd0);
    check("rest_busy", busy_cnt, 32'd300 + GAP);

    // Overflow: DEPTH+1 pushes while disabled
    cpu_write(2'd0, 32'd0);
    for (int i = 0; i <= DEPTH; i++) begin
      cpu_write(2'd2, 32'd100 + 32'(i));
      cpu_write(2'd3, 32'd3 + 32'(i));
    end
    cpu_read(2'd1, rd); check("ovf_status", rd, 32'h000A_0008);
    wr_log.delete();
    cpu_write(2'd0, 32'd5);
    cpu_read(2'd1, rd); check("ovf_cleared", rd[19], 1'b0);
    wait_idle("replay_idle", 1'b1, 2000);
    check("replay_writes", wr_log.size(), 32'd24);
    for (int i = 0; i < DEPTH; i++) check_wr("replay_freq", 3 * i, 2'd1, 32'd100 + 32'(i));
    cpu_read(2'd1, rd); check("replay_status", rd, 32'h0001_0000);

    // Mid-WAIT disable: one CTRL=0 write, popped note dropped
    cpu_write(2'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cpu_write(2'd2, 32'd500 + 32'(i));
      cpu_write(2'd3, 32'd1000);
    end
    cpu_write(2'd0, 32'd1);
    wait_playing("dis_playing");
    wr_log.delete(); we_cnt = 0;
    cpu_write(2'd0, 32'd0);
    wait_idle("dis_idle", 1'b0, 100);
    check("dis_writes", wr_log.size(), 32'd1);
    check_wr("dis_stop", 0, 2'd0, 32'd0);
    check("dis_we_cycles", we_cnt, 32'd2);
    cpu_read(2'd1, rd); check("dis_status", rd, 32'h0000_0002);

    // Mid-WAIT flush with enable and irq_en
    cpu_write(2'd0, 32'd1);
    wait_playing("flush_playing");
    wr_log.delete();
    cpu_write(2'd0, 32'd7);
    wait_idle("flush_idle", 1'b1, 100);
    check("flush_writes", wr_log.size(), 32'd1);
    check_wr("flush_stop", 0, 2'd0, 32'd0);
    cpu_read(2'd1, rd); check("flush_status", rd, 32'h0001_0000);
    cpu_read(2'd0, rd); check("flush_ctrl", rd, 32'd5);
    check("flush_irq", {31'd0, irq}, 32'd1);

    // Reset during WR_DUR cycle A
    cpu_write(2'd2, 32'd700);
    cpu_write(2'd3, 32'd50);
    begin
      int n = 0;
      while (!(bz_clk && bz_addr == 2'd2) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("dur_strobe_seen", {30'd0, bz_clk, bz_addr == 2'd2}, 32'd3);
    end
    rst_n = 1'b0;
    #1;
    check("async_bus_ctl", {29'd0, bz_clk, bz_we, bz_addr != 2'd0}, 32'd0);
    check("async_bus_din", bz_din, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_read(2'd1, rd); check("post_rst_status", rd, 32'h0001_0000);
    cpu_read(2'd0, rd); check("post_rst_ctrl", rd, 32'd0);

    check("no_double_strobe", dbl_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
